// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU data-memory master.
// Holds the access-size and FSM state encodings, plus the alignment check
// used when a pipeline command is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_RSP  = 2'b10,
    ST_ERR  = 2'b11
  } lsu_state_e;

  // Reserved size is reported through the same error path as misalignment.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_data_master_if.sv
// Data-memory request/grant/valid bus.
// master: drives data_req/addr/we/be/wdata, receives data_gnt/rvalid/rdata.
// slave : the memory-side view of the same signals.
interface lsu_data_master_if;

  logic        data_req;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_addr, data_we, data_be, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_addr, data_we, data_be, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU.
// Ports:
//   size, off   - access size and byte offset within the word
//   sign_ext    - sign-extend narrow loads
//   st_data     - right-justified store data
//   raw_rdata   - word returned by memory
//   be          - byte enables for the bus
//   wdata_sh    - store data shifted onto its byte lanes
//   ld_data     - extracted and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_size_e   size,
  input  logic [1:0]  off,
  input  logic        sign_ext,
  input  logic [31:0] st_data,
  input  logic [31:0] raw_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] ld_data
);

  logic [31:0] r;
  logic [4:0]  shamt;

  always_comb begin
    shamt    = {off, 3'b000};
    wdata_sh = st_data << shamt;
    r        = raw_rdata >> shamt;
    be       = 4'b1111;
    ld_data  = r;
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << off;
        ld_data = {{24{sign_ext & r[7]}}, r[7:0]};
      end
      SZ_HALF: begin
        be      = 4'b0011 << off;
        ld_data = {{16{sign_ext & r[15]}}, r[15:0]};
      end
      default: begin
        be      = 4'b1111;
        ld_data = r;
      end
    endcase
  end

endmodule

// File: rtl/lsu_data_master.sv
// Initiator side of the data-memory bus. Accepts one load/store command at
// a time, drives the req/gnt/rvalid handshake, and returns a one-cycle
// completion pulse with extended load data or an error flag.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   lsu_req/lsu_ready - pipeline command handshake
//   lsu_we/size/signed/addr/wdata - command fields
//   lsu_rvalid/rdata/err - completion pulse, load data, error qualifier
//   bus               - data-memory master port
module lsu_data_master
  import lsu_pkg::*;
#(
  parameter int unsigned RSP_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_req,
  output logic        lsu_ready,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_signed,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_rvalid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err,
  lsu_data_master_if.master bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(RSP_TIMEOUT);

  lsu_state_e  st_q, st_d;
  logic        we_q, we_d;
  lsu_size_e   size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] ld_data;
  logic        in_req;
  logic        timed_out;

  lsu_align u_align (
    .size      (size_q),
    .off       (addr_q[1:0]),
    .sign_ext  (sgn_q),
    .st_data   (wdata_q),
    .raw_rdata (bus.data_rdata),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .ld_data   (ld_data)
  );

  // Saturate so a stuck counter can never wrap back below the limit.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign timed_out = (cnt_q >= TIMEOUT_CNT);

  always_comb begin
    st_d     = st_q;
    we_d     = we_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    case (st_q)
      ST_IDLE: begin
        if (lsu_req) begin
          we_d    = lsu_we;
          size_d  = lsu_size_e'(lsu_size);
          sgn_d   = lsu_signed;
          addr_d  = lsu_addr;
          wdata_d = lsu_wdata;
          cnt_d   = '0;
          st_d    = lsu_misaligned(lsu_size_e'(lsu_size), lsu_addr[1:0]) ? ST_ERR : ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_inc;
        // A response in the grant cycle is illegal and deliberately ignored.
        if (bus.data_gnt) begin
          st_d = ST_RSP;
        end else if (timed_out) begin
          st_d     = ST_IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end
      end
      ST_RSP: begin
        cnt_d = cnt_inc;
        // A response arriving on the timeout cycle still completes normally.
        if (bus.data_rvalid) begin
          st_d     = ST_IDLE;
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0 : ld_data;
        end else if (timed_out) begin
          st_d     = ST_IDLE;
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end
      end
      ST_ERR: begin
        st_d = ST_IDLE;
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      sgn_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      st_q     <= st_d;
      we_q     <= we_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // Bus fields are forced to zero outside REQ so idle/reset outputs are clean.
  assign in_req          = (st_q == ST_REQ);
  assign bus.data_req    = in_req;
  assign bus.data_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.data_we     = in_req & we_q;
  assign bus.data_be     = in_req ? be : 4'b0000;
  assign bus.data_wdata  = in_req ? wdata_sh : 32'h0;

  // ERR state raises its pulse combinationally; other completions are registered.
  assign lsu_ready  = (st_q == ST_IDLE);
  assign lsu_rvalid = rvalid_q | (st_q == ST_ERR);
  assign lsu_err    = err_q | (st_q == ST_ERR);
  assign lsu_rdata  = rdata_q;

endmodule

// File: tb/tb_lsu_data_master.sv
// Directed bench for lsu_data_master: aligned loads/stores, sign handling,
// delayed grant, misaligned/reserved commands, response timeout, and reset
// during an outstanding access.
module tb_lsu_data_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_ready;
  logic        lsu_we = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_signed = 1'b0;
  logic [31:0] lsu_addr = 32'h0;
  logic [31:0] lsu_wdata = 32'h0;
  logic        lsu_rvalid;
  logic [31:0] lsu_rdata;
  logic        lsu_err;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_data_master_if bus ();

  lsu_data_master #(.RSP_TIMEOUT(16), .CNT_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsu_req    (lsu_req),
    .lsu_ready  (lsu_ready),
    .lsu_we     (lsu_we),
    .lsu_size   (lsu_size),
    .lsu_signed (lsu_signed),
    .lsu_addr   (lsu_addr),
    .lsu_wdata  (lsu_wdata),
    .lsu_rvalid (lsu_rvalid),
    .lsu_rdata  (lsu_rdata),
    .lsu_err    (lsu_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a command for one cycle; returns in the cycle after acceptance.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata);
    lsu_req    = 1'b1;
    lsu_we     = we;
    lsu_size   = size;
    lsu_signed = sgn;
    lsu_addr   = addr;
    lsu_wdata  = wdata;
    tick();
    lsu_req    = 1'b0;
  endtask

  // Grant in the first request cycle, respond in the next one.
  task automatic fast_access(input string tag, input logic we, input logic [1:0] size,
                             input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] raw, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_rdata);
    issue(we, size, sgn, addr, wdata);
    chk({tag, "_req"}, 32'(bus.data_req), 32'd1);
    chk({tag, "_addr"}, bus.data_addr, exp_addr);
    chk({tag, "_be"}, 32'(bus.data_be), 32'(exp_be));
    chk({tag, "_we"}, 32'(bus.data_we), 32'(we));
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    chk({tag, "_req_drop"}, 32'(bus.data_req), 32'd0);
    chk({tag, "_early"}, 32'(lsu_rvalid), 32'd0);
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = raw;
    tick();
    bus.data_rvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(lsu_rvalid), 32'd1);
    chk({tag, "_rdata"}, lsu_rdata, exp_rdata);
    chk({tag, "_err"}, 32'(lsu_err), 32'd0);
    chk({tag, "_ready"}, 32'(lsu_ready), 32'd1);
    tick();
    chk({tag, "_pulse_end"}, 32'(lsu_rvalid), 32'd0);
  endtask

  task automatic bad_cmd(input string tag, input logic [1:0] size, input logic [31:0] addr);
    issue(1'b0, size, 1'b0, addr, 32'h0);
    chk({tag, "_noreq"}, 32'(bus.data_req), 32'd0);
    chk({tag, "_rvalid"}, 32'(lsu_rvalid), 32'd1);
    chk({tag, "_err"}, 32'(lsu_err), 32'd1);
    chk({tag, "_rdata"}, lsu_rdata, 32'h0);
    chk({tag, "_busy"}, 32'(lsu_ready), 32'd0);
    tick();
    chk({tag, "_rvalid_end"}, 32'(lsu_rvalid), 32'd0);
    chk({tag, "_err_end"}, 32'(lsu_err), 32'd0);
    chk({tag, "_ready"}, 32'(lsu_ready), 32'd1);
  endtask

  initial begin
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'h0;

    // Reset state
    #2;
    chk("rst_ready", 32'(lsu_ready), 32'd1);
    chk("rst_rvalid", 32'(lsu_rvalid), 32'd0);
    chk("rst_err", 32'(lsu_err), 32'd0);
    chk("rst_rdata", lsu_rdata, 32'h0);
    chk("rst_req", 32'(bus.data_req), 32'd0);
    chk("rst_be", 32'(bus.data_be), 32'h0);
    chk("rst_addr", bus.data_addr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Aligned loads with fastest handshake
    fast_access("wload", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 32'h10, 4'b1111, 32'h8899AABB);
    fast_access("sbyte", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h80FF0000, 32'h10, 4'b1000, 32'hFFFFFF80);
    fast_access("ubyte", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h80FF0000, 32'h10, 4'b1000, 32'h00000080);

    // Half store with grant held off for three request cycles
    issue(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    chk("hst_req", 32'(bus.data_req), 32'd1);
    chk("hst_we", 32'(bus.data_we), 32'd1);
    chk("hst_addr", bus.data_addr, 32'h20);
    chk("hst_be", 32'(bus.data_be), 32'hC);
    chk("hst_wdata", bus.data_wdata, 32'hBEEF0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hst_hold_req", 32'(bus.data_req), 32'd1);
      chk("hst_hold_addr", bus.data_addr, 32'h20);
      chk("hst_hold_be", 32'(bus.data_be), 32'hC);
      chk("hst_hold_wdata", bus.data_wdata, 32'hBEEF0000);
    end
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    chk("hst_req_drop", 32'(bus.data_req), 32'd0);
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h12345678;
    tick();
    bus.data_rvalid = 1'b0;
    chk("hst_rvalid", 32'(lsu_rvalid), 32'd1);
    chk("hst_rdata", lsu_rdata, 32'h0);
    chk("hst_err", 32'(lsu_err), 32'd0);
    tick();

    // Response coinciding with grant is ignored; the following one is used
    issue(1'b0, 2'b01, 1'b1, 32'h02, 32'h0);
    chk("shalf_be", 32'(bus.data_be), 32'hC);
    chk("shalf_addr", bus.data_addr, 32'h0);
    bus.data_gnt    = 1'b1;
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h11111111;
    tick();
    bus.data_gnt    = 1'b0;
    bus.data_rdata  = 32'h80017FFF;
    chk("shalf_early", 32'(lsu_rvalid), 32'd0);
    tick();
    bus.data_rvalid = 1'b0;
    chk("shalf_rvalid", 32'(lsu_rvalid), 32'd1);
    chk("shalf_rdata", lsu_rdata, 32'hFFFF8001);
    tick();

    // Misaligned word and reserved size
    bad_cmd("misal", 2'b10, 32'h05);
    bad_cmd("rsvd", 2'b11, 32'h10);

    // Response arriving on the timeout cycle still completes normally
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    repeat (15) tick();
    chk("edge_busy", 32'(lsu_ready), 32'd0);
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hCAFEF00D;
    tick();
    bus.data_rvalid = 1'b0;
    chk("edge_rvalid", 32'(lsu_rvalid), 32'd1);
    chk("edge_err", 32'(lsu_err), 32'd0);
    chk("edge_rdata", lsu_rdata, 32'hCAFEF00D);
    tick();

    // Response timeout, late response ignored, then a normal access
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    repeat (15) tick();
    chk("to_not_yet", 32'(lsu_rvalid), 32'd0);
    chk("to_busy", 32'(lsu_ready), 32'd0);
    tick();
    chk("to_rvalid", 32'(lsu_rvalid), 32'd1);
    chk("to_err", 32'(lsu_err), 32'd1);
    chk("to_rdata", lsu_rdata, 32'h0);
    chk("to_ready", 32'(lsu_ready), 32'd1);
    tick();
    chk("to_pulse_end", 32'(lsu_rvalid), 32'd0);
    tick();
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'h55AA55AA;
    tick();
    bus.data_rvalid = 1'b0;
    chk("late_ignored", 32'(lsu_rvalid), 32'd0);
    chk("late_ready", 32'(lsu_ready), 32'd1);
    fast_access("after_to", 1'b1, 2'b10, 1'b0, 32'h44, 32'h01020304, 32'hDEADBEEF, 32'h44, 4'b1111, 32'h0);

    // Reset asserted while waiting for a response
    issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
    bus.data_gnt = 1'b1;
    tick();
    bus.data_gnt = 1'b0;
    chk("rr_busy", 32'(lsu_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rr_ready", 32'(lsu_ready), 32'd1);
    chk("rr_req", 32'(bus.data_req), 32'd0);
    chk("rr_rvalid", 32'(lsu_rvalid), 32'd0);
    chk("rr_err", 32'(lsu_err), 32'd0);
    chk("rr_be", 32'(bus.data_be), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.data_rvalid = 1'b1;
    bus.data_rdata  = 32'hFFFFFFFF;
    tick();
    bus.data_rvalid = 1'b0;
    chk("rr_stray_rvalid", 32'(lsu_rvalid), 32'd0);
    chk("rr_stray_rdata", lsu_rdata, 32'h0);
    tick();
    chk("rr_stray_rvalid2", 32'(lsu_rvalid), 32'd0);
    chk("rr_idle_ready", 32'(lsu_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
